adder_share_ctrl: RTL

//  Shares one combinational W-bit adder (sum width W+1) between N_REQ requesters.

---
 rtl/adder_share_pkg.sv | 15 +
 rtl/adder_share_ctrl_rr_arbiter.sv | 38 +++
 rtl/adder_share_ctrl.sv | 113 +++++++++++
 3 files changed

// File: rtl/adder_share_pkg.sv
// Shared types and defaults for the time-multiplexed adder controller.
// The optional per-requester grant statistics are enabled by ADDER_SHARE_STATS_EN.
package adder_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 5;
  localparam int STAT_W    = 8;

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first asserted request at or
// after the pointer (wrapping), returning a one-hot grant and its index.
module rr_arbiter
  import adder_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);

  localparam int IW = $clog2(N_REQ);

  logic [IW:0]   pos;
  logic [IW-1:0] cand;

  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    pos  = '0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N_REQ)) pos = pos - (IW+1)'(N_REQ);
      cand = pos[IW-1:0];
      if (!any && req[cand]) begin
        gnt[cand] = 1'b1;
        idx       = cand;
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_share_ctrl.sv
// Shares one external combinational adder between N_REQ valid/ready requesters.
// Define ADDER_SHARE_STATS_EN to add per-requester wrapping grant counters (grant_cnt).
module adder_share_ctrl
  import adder_share_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic [W-1:0]             add_a,
  output logic [W-1:0]             add_b,
  input  logic [W:0]               add_q,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic [W:0]               rsp_q
`ifdef ADDER_SHARE_STATS_EN
  ,
  output logic [N_REQ*STAT_W-1:0]  grant_cnt
`endif
);

  localparam int IW = $clog2(N_REQ);

  state_t        state, state_d;
  logic [IW-1:0] ptr;
  logic [N_REQ-1:0] gnt;
  logic [IW-1:0] g_idx;
  logic          g_any;
  logic          accept;
  logic [W-1:0]  a_arr [N_REQ];
  logic [W-1:0]  b_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*W +: W];
    assign b_arr[i] = req_b[i*W +: W];
  end

  rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .gnt (gnt),
    .idx (g_idx),
    .any (g_any)
  );

  // Grant is offered only while IDLE, so req_ready is at most one-hot.
  always_comb begin
    state_d   = state;
    req_ready = '0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (g_any) begin
          req_ready = gnt;
          accept    = 1'b1;
          state_d   = CALC;
        end
      end
      CALC:    state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      add_a     <= '0;
      add_b     <= '0;
      rsp_id    <= '0;
      rsp_q     <= '0;
      rsp_valid <= 1'b0;
    end else begin
      state <= state_d;
      if (accept) begin
        add_a  <= a_arr[g_idx];
        add_b  <= b_arr[g_idx];
        rsp_id <= g_idx;
        ptr    <= (g_idx == IW'(N_REQ-1)) ? '0 : g_idx + 1'b1;
      end
      // Operands have been stable for a full cycle here; capture the sum.
      if (state == CALC) begin
        rsp_q     <= add_q;
        rsp_valid <= 1'b1;
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end

`ifdef ADDER_SHARE_STATS_EN
  logic [STAT_W-1:0] cnt [N_REQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else if (accept) begin
      cnt[g_idx] <= cnt[g_idx] + 1'b1;
    end
  end

  for (genvar i = 0; i < N_REQ; i++) begin : g_cnt_out
    assign grant_cnt[i*STAT_W +: STAT_W] = cnt[i];
  end
`endif

endmodule
